// File: rtl/framebuffer_reader_pkg.sv
// -----------------------------------------------------------------------------
// framebuffer_reader_pkg
// Shared constants and types for the framebuffer reader and the text writer
// that fills the same framebuffer RAM.
//   FB_BYTES      : bytes per frame (PAGES x COLS_PER_PAGE)
//   ADDR_W        : framebuffer RAM address width
//   COLS_PER_PAGE : columns per display page; one byte = 8 vertical pixels
//   PAGES         : display pages per frame
//   fb_state_e    : reader FSM state encoding
//   fb_byte_t     : byte plus page-start flag as stored in the output FIFO
// -----------------------------------------------------------------------------
package framebuffer_reader_pkg;

  localparam int FB_BYTES      = 1024;
  localparam int ADDR_W        = 14;
  localparam int COLS_PER_PAGE = 128;
  localparam int PAGES         = 8;
  localparam int COL_W         = $clog2(COLS_PER_PAGE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fb_state_e;

  typedef struct packed {
    logic       page_start;
    logic [7:0] data;
  } fb_byte_t;

endpackage

// File: rtl/framebuffer_reader_if.sv
// -----------------------------------------------------------------------------
// framebuffer_reader_if
// Bundles the framebuffer RAM read port and the byte stream toward the display
// serializer. Signal directions are named from the reader's point of view.
//   o_ram_address / o_ram_rd_en : read request, data returns one cycle later
//   i_ram_data                  : RAM read data
//   o_byte_data / o_byte_valid  : byte stream out, i_byte_ready accepts
//   o_page_start                : flags the first byte of each page
// Modports: master = reader, slave = RAM + serializer side.
// -----------------------------------------------------------------------------
interface framebuffer_reader_if #(
  parameter int ADDR_W = framebuffer_reader_pkg::ADDR_W
);

  logic [ADDR_W-1:0] o_ram_address;
  logic              o_ram_rd_en;
  logic [7:0]        i_ram_data;
  logic [7:0]        o_byte_data;
  logic              o_byte_valid;
  logic              i_byte_ready;
  logic              o_page_start;

  modport master (
    output o_ram_address,
    output o_ram_rd_en,
    input  i_ram_data,
    output o_byte_data,
    output o_byte_valid,
    input  i_byte_ready,
    output o_page_start
  );

  modport slave (
    input  o_ram_address,
    input  o_ram_rd_en,
    output i_ram_data,
    input  o_byte_data,
    input  o_byte_valid,
    output i_byte_ready,
    input  o_page_start
  );

endinterface

// File: rtl/framebuffer_reader_out_fifo.sv
// -----------------------------------------------------------------------------
// fb_out_fifo
// Two-entry FIFO of byte + page-start flag with a valid/ready output side.
//   clk, i_rst_n : clock, asynchronous active-low reset (FIFO empties, data 0)
//   i_push       : write i_push_data this cycle
//   o_valid      : head entry present on o_data
//   i_ready      : consumer takes the head when o_valid is also high
//   o_count      : number of stored entries (0..2)
// Push and pop in the same cycle are both honoured, also when full.
// -----------------------------------------------------------------------------
module fb_out_fifo
  import framebuffer_reader_pkg::*;
(
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  fb_byte_t   i_push_data,
  output logic       o_valid,
  output fb_byte_t   o_data,
  input  logic       i_ready,
  output logic [1:0] o_count
);

  fb_byte_t   mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       pop;
  logic       push_ok;

  assign pop     = (count_q != 2'd0) && i_ready;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign push_ok = i_push && ((count_q != 2'd2) || pop);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= i_push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign o_valid = (count_q != 2'd0);
  assign o_data  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/framebuffer_reader.sv
// -----------------------------------------------------------------------------
// framebuffer_reader
// Streams one full frame (FB_BYTES bytes, ascending address) from the
// framebuffer RAM to the display serializer on each accepted frame request.
//   clk            : single clock, rising edge
//   i_rst_n        : asynchronous active-low reset; abandons any frame
//   i_frame_start  : one-cycle request, honoured only in IDLE
//   o_busy         : high from frame acceptance until the done cycle
//   o_frame_done   : one-cycle pulse right after the last byte handshake
//   bus (master)   : RAM read port and byte stream, see framebuffer_reader_if
// Reads are issued only while the FIFO can absorb every outstanding byte, so
// returned data is never dropped and i_byte_ready back-pressure stalls reads.
// -----------------------------------------------------------------------------
module framebuffer_reader
  import framebuffer_reader_pkg::*;
#(
  parameter int FB_BYTES = framebuffer_reader_pkg::FB_BYTES,
  parameter int ADDR_W   = framebuffer_reader_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic                    i_frame_start,
  output logic                    o_busy,
  output logic                    o_frame_done,
  framebuffer_reader_if.master    bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_BYTES - 1);

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q;
  logic              inflight_page_q;
  logic              rd_en;

  fb_byte_t          fifo_head;
  fb_byte_t          fifo_push_data;
  logic              fifo_valid;
  logic [1:0]        fifo_count;
  logic              handshake;
  logic [2:0]        slots_used;

  assign handshake = fifo_valid && bus.i_byte_ready;

  // Slots committed after this edge: stored bytes plus the read in flight,
  // minus the byte leaving now. Counting the departing byte keeps one byte
  // per cycle with ready held high while never exceeding two entries.
  assign slots_used = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, handshake};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_frame_start) begin
          addr_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (slots_used < 3'd2) begin
          rd_en = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Finish in the cycle right after the last handshake: nothing in
        // flight and the FIFO is empty now or empties at this edge.
        if (!inflight_q && ((fifo_count == 2'd0) ||
                            ((fifo_count == 2'd1) && handshake))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_page_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      inflight_q <= rd_en;
      if (rd_en) begin
        inflight_page_q <= (addr_q[COL_W-1:0] == '0);
      end
    end
  end

  assign fifo_push_data = '{page_start: inflight_page_q, data: bus.i_ram_data};

  fb_out_fifo u_out_fifo (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_push      (inflight_q),
    .i_push_data (fifo_push_data),
    .o_valid     (fifo_valid),
    .o_data      (fifo_head),
    .i_ready     (bus.i_byte_ready),
    .o_count     (fifo_count)
  );

  assign bus.o_ram_address = addr_q;
  assign bus.o_ram_rd_en   = rd_en;
  assign bus.o_byte_data   = fifo_head.data;
  assign bus.o_byte_valid  = fifo_valid;
  assign bus.o_page_start  = fifo_head.page_start && fifo_valid;

  assign o_busy       = (state_q == FETCH) || (state_q == DRAIN);
  assign o_frame_done = (state_q == DONE);

endmodule

// File: tb/tb_framebuffer_reader.sv
// -----------------------------------------------------------------------------
// tb_framebuffer_reader
// Randomized bench: a RAM model answers reads one cycle after the strobe, the
// stimulus side queues the expected frame (bytes in address order with their
// page-start flags) and a negedge monitor pops and compares every handshake.
// -----------------------------------------------------------------------------
module tb_framebuffer_reader;
  import framebuffer_reader_pkg::*;

  localparam int NB = FB_BYTES;
  localparam int AW = ADDR_W;

  logic clk         = 1'b0;
  logic rst_n       = 1'b1;
  logic frame_start = 1'b0;
  logic busy;
  logic frame_done;

  framebuffer_reader_if #(.ADDR_W(AW)) bus ();

  framebuffer_reader #(.FB_BYTES(NB), .ADDR_W(AW)) dut (
    .clk           (clk),
    .i_rst_n       (rst_n),
    .i_frame_start (frame_start),
    .o_busy        (busy),
    .o_frame_done  (frame_done),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency
  logic [7:0] ram_mem [2**AW];
  always @(posedge clk) begin
    if (bus.o_ram_rd_en) bus.i_ram_data <= ram_mem[bus.o_ram_address];
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ready driver: 0 = held high, 1 = random 30% high, 2 = manual_ready
  int   ready_mode   = 0;
  logic manual_ready = 1'b0;
  initial begin
    bus.i_byte_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.i_byte_ready = 1'b1;
        1:       bus.i_byte_ready = ($urandom_range(0, 99) < 30);
        default: bus.i_byte_ready = manual_ready;
      endcase
    end
  end

  // Scoreboard queue: {page_start, data}
  logic [8:0] exp_q [$];

  int   issued, accepted, done_seen, first_valid_cyc, last_hs_cyc, done_cyc, start_cyc;
  bit   seen_valid, stall_pending;
  logic [7:0] held_data;
  logic held_page;

  initial begin
    logic [8:0] e;
    issued = 0; accepted = 0; done_seen = 0; first_valid_cyc = 0;
    last_hs_cyc = -10; done_cyc = 0; seen_valid = 0; stall_pending = 0;
    held_data = '0; held_page = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        issued = 0; accepted = 0; seen_valid = 0; stall_pending = 0; last_hs_cyc = -10;
      end else begin
        if (stall_pending) begin
          chk("hold_valid", bus.o_byte_valid, 1);
          chk("hold_data", bus.o_byte_data, held_data);
          chk("hold_page", bus.o_page_start, held_page);
        end
        if (!bus.o_byte_valid) chk("page_start_idle", bus.o_page_start, 0);
        if (bus.o_byte_valid && !seen_valid) begin
          seen_valid = 1;
          first_valid_cyc = cyc;
        end
        if (bus.o_byte_valid && bus.i_byte_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got data %0d, expected no byte (t=%0t)",
                     bus.o_byte_data, $time);
          end else begin
            e = exp_q.pop_front();
            chk("byte_data", bus.o_byte_data, e[7:0]);
            chk("byte_page_start", bus.o_page_start, e[8]);
          end
          accepted++;
          last_hs_cyc = cyc;
        end
        if (bus.o_ram_rd_en) begin
          chk("rd_addr_ascending", bus.o_ram_address, issued);
          issued++;
        end
        chk("outstanding_le2", (issued - accepted) <= 2, 1);
        stall_pending = bus.o_byte_valid && !bus.i_byte_ready;
        held_data     = bus.o_byte_data;
        held_page     = bus.o_page_start;
        if (frame_done) begin
          done_seen++;
          done_cyc = cyc;
          chk("done_after_last_hs", cyc - last_hs_cyc, 1);
          chk("done_queue_empty", exp_q.size(), 0);
          chk("done_busy_low", busy, 0);
          issued = 0; accepted = 0; seen_valid = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ram(input bit ident);
    for (int a = 0; a < NB; a++) ram_mem[a] = ident ? a[7:0] : 8'($urandom);
  endtask

  task automatic start_frame(input bit accept);
    logic [8:0] v;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (accept) begin
      start_cyc = cyc;
      for (int a = 0; a < NB; a++) begin
        v = {((a % COLS_PER_PAGE) == 0), ram_mem[a]};
        exp_q.push_back(v);
      end
    end
  endtask

  task automatic wait_done(input int base, input int bound, input string name);
    int n = 0;
    while (done_seen == base && n < bound) begin
      tick();
      n++;
    end
    chk(name, done_seen, base + 1);
  endtask

  task automatic wait_accepted(input int target, input int bound, input string name);
    int n = 0;
    while (accepted < target && n < bound) begin
      tick();
      n++;
    end
    chk(name, accepted >= target, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},     busy, 0);
    chk({tag, "_done"},     frame_done, 0);
    chk({tag, "_rd_en"},    bus.o_ram_rd_en, 0);
    chk({tag, "_valid"},    bus.o_byte_valid, 0);
    chk({tag, "_page"},     bus.o_page_start, 0);
    chk({tag, "_address"},  bus.o_ram_address, 0);
    chk({tag, "_data"},     bus.o_byte_data, 0);
  endtask

  initial begin
    int base;
    int n;

    // Reset
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // A: identity RAM, ready held high, exact latency and done cycle
    fill_ram(1);
    ready_mode = 0;
    base = done_seen;
    start_frame(1);
    chk("A_busy", busy, 1);
    wait_done(base, 3000, "A_done_seen");
    chk("A_first_valid_latency", first_valid_cyc - start_cyc, 2);
    chk("A_done_cycle", done_cyc - start_cyc, NB + 2);
    chk("A_idle_busy", busy, 0);
    $display("A: identity frame, done %0d cycles after start", done_cyc - start_cyc);

    // B: random data, random 30% ready
    fill_ram(0);
    ready_mode = 1;
    base = done_seen;
    start_frame(1);
    wait_done(base, 20000, "B_done_seen");
    ready_mode = 0;
    tick();
    $display("B: random ready frame finished, %0d checks so far", checks);

    // C: accept byte 0 then stall 50 cycles
    fill_ram(0);
    manual_ready = 1'b0;
    ready_mode = 2;
    base = done_seen;
    start_frame(1);
    n = 0;
    while (!bus.o_byte_valid && n < 20) begin
      tick();
      n++;
    end
    chk("C_first_valid", bus.o_byte_valid, 1);
    manual_ready = 1'b1;
    tick();
    manual_ready = 1'b0;
    repeat (50) tick();
    chk("C_accepted_during_stall", accepted, 1);
    chk("C_buffered_during_stall", issued - accepted, 2);
    manual_ready = 1'b1;
    wait_done(base, 3000, "C_done_seen");
    ready_mode = 0;
    tick();
    $display("C: stalled frame finished");

    // D: extra frame_start at byte 500 and in the DONE cycle
    fill_ram(1);
    base = done_seen;
    start_frame(1);
    wait_accepted(500, 2000, "D_reach_500");
    start_frame(0);
    chk("D_busy_after_extra", busy, 1);
    n = 0;
    while (!frame_done && n < 2000) begin
      tick();
      n++;
    end
    chk("D_in_done_cycle", frame_done, 1);
    start_frame(0);
    for (int i = 0; i < 10; i++) begin
      chk("D_idle_busy", busy, 0);
      chk("D_idle_rd_en", bus.o_ram_rd_en, 0);
      tick();
    end
    chk("D_done_count", done_seen, base + 1);
    $display("D: ignored starts, done pulses %0d", done_seen - base);

    // E: reset at byte 300, then a clean new frame
    fill_ram(0);
    base = done_seen;
    start_frame(1);
    wait_accepted(300, 2000, "E_reach_300");
    rst_n = 1'b0;
    exp_q.delete();
    #1 check_reset_outputs("E_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("E_post_reset_valid", bus.o_byte_valid, 0);
      chk("E_post_reset_busy", busy, 0);
      tick();
    end
    chk("E_no_done_aborted", done_seen, base);
    fill_ram(0);
    start_frame(1);
    wait_done(base, 3000, "E_new_done");
    chk("E_first_valid_latency", first_valid_cyc - start_cyc, 2);
    chk("E_done_cycle", done_cyc - start_cyc, NB + 2);
    $display("E: frame after reset finished");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
